// File: rtl/sha_round_sequencer_if.sv
// rtl/sha_round_sequencer_if.sv - hash-control and counter/datapath signal bundle for sha_round_sequencer
interface sha_round_sequencer_if;
   logic       START;
   logic       ABORT;
   logic       STALL;
   logic [7:0] CNT_Q;
   logic       CNT_CLK;
   logic       CNT_CLR;
   logic [7:0] ROUND;
   logic       ROUND_EN;
   logic       LOAD_W;
   logic       EXPAND_W;
   logic       FINAL_ADD;
   logic       BUSY;
   logic       DONE;
   logic       ERR;

   modport master (
      output START, ABORT, STALL, CNT_Q,
      input  CNT_CLK, CNT_CLR, ROUND, ROUND_EN, LOAD_W, EXPAND_W,
      input  FINAL_ADD, BUSY, DONE, ERR
   );

   modport slave (
      input  START, ABORT, STALL, CNT_Q,
      output CNT_CLK, CNT_CLR, ROUND, ROUND_EN, LOAD_W, EXPAND_W,
      output FINAL_ADD, BUSY, DONE, ERR
   );
endinterface

// File: rtl/sha_round_sequencer.sv
// rtl/sha_round_sequencer.sv - SHA-256 round sequencer driving an external cascaded 8-bit ripple round counter
// Optional counter readback check enabled by defining SHA_ROUND_READBACK_CHECK_EN.
module sha_round_sequencer #(
   parameter int ROUNDS     = 64,
   parameter int LOAD_WORDS = 16,
   parameter int SETTLE_CYC = 2
) (
   input logic                  CLK,
   input logic                  CLR_N,
   sha_round_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_EXEC, S_STEP, S_SETTLE, S_VERIFY, S_FINAL, S_FAULT
   } state_t;

   localparam logic [7:0] LAST_ROUND  = 8'(ROUNDS);
   localparam logic [7:0] LOAD_LIM    = 8'(LOAD_WORDS);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

   state_t     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic [7:0] round_q, round_d;
   logic       cnt_clk_q, cnt_clk_d;
   logic       cnt_clr_q, cnt_clr_d;
   logic       round_en_q, round_en_d;
   logic       load_w_q, load_w_d;
   logic       expand_w_q, expand_w_d;
   logic       final_add_q, final_add_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic [7:0] round_nxt;
   logic       readback_ok;

   assign round_nxt = round_q + 8'd1;

`ifdef SHA_ROUND_READBACK_CHECK_EN
   assign readback_ok = (bus.CNT_Q == round_nxt);
`else
   logic unused_cnt_q;
   assign unused_cnt_q = ^bus.CNT_Q;
   assign readback_ok  = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      round_d = round_q;
      err_d   = err_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               state_d = S_CLEAR;
               wait_d  = '0;
               round_d = '0;
               err_d   = 1'b0;
            end
         end
         S_CLEAR: begin
            wait_d = wait_q + 4'd1;
            if (wait_q == 4'd1) state_d = S_EXEC;
         end
         S_EXEC: begin
            // round_en_q already reflects STALL sampled on the way in
            if (round_en_q) state_d = S_STEP;
         end
         S_STEP: begin
            state_d = S_SETTLE;
            wait_d  = '0;
         end
         S_SETTLE: begin
            wait_d = wait_q + 4'd1;
            if (wait_q == SETTLE_LAST) state_d = S_VERIFY;
         end
         S_VERIFY: begin
            if (!readback_ok) begin
               state_d = S_FAULT;
               err_d   = 1'b1;
            end else begin
               round_d = round_nxt;
               state_d = (round_nxt == LAST_ROUND) ? S_FINAL : S_EXEC;
            end
         end
         S_FINAL: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase

      if (bus.ABORT && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         round_d = round_q;
         err_d   = err_q;
         done_d  = 1'b0;
      end

      round_en_d  = (state_d == S_EXEC) && !bus.STALL;
      load_w_d    = round_en_d && (round_d < LOAD_LIM);
      expand_w_d  = round_en_d && !(round_d < LOAD_LIM);
      final_add_d = (state_d == S_FINAL);
      busy_d      = (state_d != S_IDLE);
      cnt_clk_d   = (state_d != S_STEP);
      // Aborting out of STEP raises CNT_CLK first and CNT_CLR one cycle later
      cnt_clr_d   = ((state_d == S_IDLE) || (state_d == S_CLEAR)) && cnt_clk_q;
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q     <= S_IDLE;
         wait_q      <= '0;
         round_q     <= '0;
         cnt_clk_q   <= 1'b1;
         cnt_clr_q   <= 1'b1;
         round_en_q  <= 1'b0;
         load_w_q    <= 1'b0;
         expand_w_q  <= 1'b0;
         final_add_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         round_q     <= round_d;
         cnt_clk_q   <= cnt_clk_d;
         cnt_clr_q   <= cnt_clr_d;
         round_en_q  <= round_en_d;
         load_w_q    <= load_w_d;
         expand_w_q  <= expand_w_d;
         final_add_q <= final_add_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.CNT_CLK   = cnt_clk_q;
   assign bus.CNT_CLR   = cnt_clr_q;
   assign bus.ROUND     = round_q;
   assign bus.ROUND_EN  = round_en_q;
   assign bus.LOAD_W    = load_w_q;
   assign bus.EXPAND_W  = expand_w_q;
   assign bus.FINAL_ADD = final_add_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.ERR       = err_q;
endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb/tb_sha_round_sequencer.sv - self-checking bench for sha_round_sequencer (default and 2-round builds)
module tb_sha_round_sequencer;
   localparam int PER = 5;
   localparam int LEN = 3 + 64 * PER + 1;

   typedef struct {
      logic [7:0] round;
      bit         load;
   } exp_t;

   typedef struct {
      int kind;
      int exp_pulses;
      bit exp_done;
      int exp_len;
   } vec_t;

   logic clk = 1'b0;
   logic CLR_N;
   int   total = 0;
   int   bad = 0;
   bit   inject = 1'b0;
   exp_t sb[$];
   vec_t vecs[4];
   logic [7:0] cnt_m = 8'd0;
   logic [7:0] cnt_s = 8'd0;

   sha_round_sequencer_if u_if ();
   sha_round_sequencer_if s_if ();

   sha_round_sequencer dut (
      .CLK   (clk),
      .CLR_N (CLR_N),
      .bus   (u_if.slave)
   );

   sha_round_sequencer #(.ROUNDS(2), .LOAD_WORDS(1), .SETTLE_CYC(1)) dut_small (
      .CLK   (clk),
      .CLR_N (CLR_N),
      .bus   (s_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge u_if.CNT_CLR or negedge u_if.CNT_CLK)
      if (u_if.CNT_CLR) cnt_m <= 8'd0;
      else              cnt_m <= cnt_m + 8'd1;
   assign u_if.CNT_Q = (inject && cnt_m == 8'h0A) ? 8'h09 : cnt_m;

   always @(posedge s_if.CNT_CLR or negedge s_if.CNT_CLK)
      if (s_if.CNT_CLR) cnt_s <= 8'd0;
      else              cnt_s <= cnt_s + 8'd1;
   assign s_if.CNT_Q = cnt_s;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int   cyc, pulses, last_en, trig, falls, fin_cyc, done_cyc;
      bit   prev_clk, prev_clr, ending;
      exp_t e;
      cyc = 0; pulses = 0; last_en = -1; trig = -1; falls = 0;
      fin_cyc = -1; done_cyc = -1; prev_clk = 1'b1; prev_clr = 1'b1; ending = 1'b0;
      sb.delete();
      for (int r = 0; r < v.exp_pulses; r++) begin
         e.round = 8'(r);
         e.load  = (r < 16);
         sb.push_back(e);
      end
      inject = (v.kind == 3);
      @(negedge clk);
      u_if.START = 1'b1;
      while (!ending && cyc < 600) begin
         @(negedge clk);
         cyc++;
         u_if.START = 1'b0;
         if (cyc == 1) begin
            check("start_busy", u_if.BUSY, 1);
            check("start_err_clear", u_if.ERR, 0);
            check("start_clr", u_if.CNT_CLR, 1);
         end
         if (!u_if.CNT_CLK && u_if.CNT_CLR) check("clk_low_while_clr", 1, 0);
         if ((prev_clk != u_if.CNT_CLK) && (prev_clr != u_if.CNT_CLR)) check("clk_clr_same_cycle", 1, 0);
         if (prev_clk && !u_if.CNT_CLK) falls++;
         prev_clk = u_if.CNT_CLK;
         prev_clr = u_if.CNT_CLR;
         if (u_if.ROUND_EN) begin
            if (sb.size() == 0) begin
               check("round_en_unexpected", u_if.ROUND, 255);
            end else begin
               e = sb.pop_front();
               check("round_idx", u_if.ROUND, e.round);
               check("load_w", u_if.LOAD_W, e.load);
               check("expand_w", u_if.EXPAND_W, !e.load);
            end
            if (last_en >= 0)
               check("round_spacing", cyc - last_en, PER + ((v.kind == 1 && u_if.ROUND == 8'd20) ? 7 : 0));
            last_en = cyc;
            pulses++;
            if (v.kind == 1 && u_if.ROUND == 8'd19) trig = cyc + 4;
            if (v.kind == 2 && u_if.ROUND == 8'd30) trig = cyc + 2;
`ifdef SHA_ROUND_READBACK_CHECK_EN
            if (v.kind == 3 && u_if.ROUND == 8'd9) trig = cyc + 5;
`endif
         end
         if (u_if.FINAL_ADD) fin_cyc = cyc;
         if (u_if.DONE) begin
            done_cyc = cyc;
            ending   = 1'b1;
            check("done_busy_low", u_if.BUSY, 0);
            check("done_round", u_if.ROUND, 64);
            check("done_err", u_if.ERR, 0);
         end
         if (v.kind == 1 && trig > 0 && cyc > trig && cyc <= trig + 7)
            check("stall_quiet", {u_if.ROUND_EN, u_if.CNT_CLK}, 2'b01);
         if (v.kind == 1 && cyc == trig) u_if.STALL = 1'b1;
         if (v.kind == 1 && trig > 0 && cyc == trig + 7) u_if.STALL = 1'b0;
         if (v.kind == 2 && cyc == trig) begin
            u_if.ABORT = 1'b1;
            @(negedge clk);
            cyc++;
            check("abort_idle", u_if.BUSY, 0);
            check("abort_clr", u_if.CNT_CLR, 1);
            check("abort_clk", u_if.CNT_CLK, 1);
            check("abort_no_strobe", {u_if.DONE, u_if.FINAL_ADD}, 2'b00);
            u_if.ABORT = 1'b0;
            ending = 1'b1;
         end
         if (v.kind == 3 && cyc == trig) begin
            check("fault_err", u_if.ERR, 1);
            check("fault_busy", u_if.BUSY, 1);
            repeat (8) begin
               @(negedge clk);
               cyc++;
               check("fault_quiet", {u_if.ROUND_EN, u_if.CNT_CLK, u_if.FINAL_ADD, u_if.BUSY}, 4'b0101);
            end
            u_if.ABORT = 1'b1;
            @(negedge clk);
            cyc++;
            check("fault_abort_idle", u_if.BUSY, 0);
            check("fault_abort_clr", u_if.CNT_CLR, 1);
            check("fault_err_sticky", u_if.ERR, 1);
            check("fault_no_done", u_if.DONE, 0);
            u_if.ABORT = 1'b0;
            ending = 1'b1;
         end
      end
      if (!ending) check("run_timeout", 0, 1);
      check("pulse_count", pulses, v.exp_pulses);
      check("counter_falls", falls, pulses);
      if (v.exp_done) begin
         check("run_len", done_cyc, v.exp_len);
         check("final_before_done", fin_cyc, done_cyc - 1);
         @(negedge clk);
         check("done_one_cycle", u_if.DONE, 0);
      end else begin
         check("no_done_no_final", {done_cyc == -1, fin_cyc == -1}, 2'b11);
      end
   endtask

   initial begin
      int n, k, fin, done;
      int en_cyc[4];
      bit en_load[4];
      bit en_exp[4];

      vecs[0] = '{0, 64, 1'b1, LEN};
`ifdef SHA_ROUND_READBACK_CHECK_EN
      vecs[1] = '{3, 10, 1'b0, 0};
`else
      vecs[1] = '{3, 64, 1'b1, LEN};
`endif
      vecs[2] = '{1, 64, 1'b1, LEN + 7};
      vecs[3] = '{2, 31, 1'b0, 0};

      CLR_N = 1'b0;
      u_if.START = 1'b0; u_if.ABORT = 1'b0; u_if.STALL = 1'b0;
      s_if.START = 1'b0; s_if.ABORT = 1'b0; s_if.STALL = 1'b0;
      #12;
      check("rst_clk", u_if.CNT_CLK, 1);
      check("rst_clr", u_if.CNT_CLR, 1);
      check("rst_round", u_if.ROUND, 0);
      check("rst_strobes", {u_if.ROUND_EN, u_if.LOAD_W, u_if.EXPAND_W, u_if.FINAL_ADD, u_if.DONE, u_if.ERR, u_if.BUSY}, 0);
      check("rst_small", {s_if.CNT_CLK, s_if.CNT_CLR, s_if.BUSY, s_if.ERR}, 4'b1100);
      @(negedge clk);
      CLR_N = 1'b1;
      u_if.ABORT = 1'b1;
      @(negedge clk);
      u_if.ABORT = 1'b0;
      check("abort_in_idle", {u_if.BUSY, u_if.CNT_CLR}, 2'b01);

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      inject = 1'b0;
      @(negedge clk);
      u_if.START = 1'b1;
      @(negedge clk);
      u_if.START = 1'b0;
      n = 0;
      while (!(u_if.ROUND_EN && u_if.ROUND == 8'd5) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("mid_reset_reach", n < 200, 1);
      @(negedge clk);
      check("step_clk_low", u_if.CNT_CLK, 0);
      #2 CLR_N = 1'b0;
      #1;
      check("async_rst_clk", u_if.CNT_CLK, 1);
      check("async_rst_clr", u_if.CNT_CLR, 1);
      check("async_rst_round", u_if.ROUND, 0);
      check("async_rst_strobes", {u_if.ROUND_EN, u_if.LOAD_W, u_if.EXPAND_W, u_if.FINAL_ADD, u_if.DONE, u_if.BUSY}, 0);
      @(negedge clk);
      CLR_N = 1'b1;

      @(negedge clk);
      s_if.START = 1'b1;
      k = 0; fin = -1; done = -1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(negedge clk);
         s_if.START = 1'b0;
         if (s_if.ROUND_EN && k < 4) begin
            en_cyc[k] = cyc; en_load[k] = s_if.LOAD_W; en_exp[k] = s_if.EXPAND_W;
            k++;
         end
         if (s_if.FINAL_ADD) fin = cyc;
         if (s_if.DONE && done < 0) done = cyc;
      end
      check("small_pulses", k, 2);
      check("small_first_en", en_cyc[0], 3);
      check("small_spacing", en_cyc[1] - en_cyc[0], 4);
      check("small_phase0", {en_load[0], en_exp[0]}, 2'b10);
      check("small_phase1", {en_load[1], en_exp[1]}, 2'b01);
      check("small_final", fin, 11);
      check("small_done", done, 12);
      check("small_idle", {s_if.BUSY, s_if.ERR, s_if.ROUND}, {2'b00, 8'd2});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
